// File: rtl/pb_debounce_multi_if.sv
// pb_debounce_multi_if: raw button inputs and conditioned event outputs for pb_debounce_multi.
// Latency: none; this is a plain signal bundle.
// Backpressure: none; every signal is a level or a one-cycle pulse.
interface pb_debounce_multi_if #(
   parameter int NUM_PB = 4
);
   logic [NUM_PB-1:0] PB;
   logic [NUM_PB-1:0] level;
   logic [NUM_PB-1:0] pressed;
   logic [NUM_PB-1:0] released;
   logic [NUM_PB-1:0] long_press;

   // master drives the raw buttons and consumes events; slave is the conditioner
   modport master (output PB, input level, pressed, released, long_press);
   modport slave  (input PB, output level, pressed, released, long_press);
endinterface

// File: rtl/pb_debounce_multi.sv
// pb_debounce_multi: per-channel synchroniser + debouncer with press/release/long-press pulses and level.
// Latency: SYNC_STAGES+DB_CYCLES clocks from PB change to pulse/level; long_press LONG_CYCLES after pressed.
// Backpressure: none; pulses cannot be stalled. Define PB_AUTOREPEAT_EN to repeat long_press while held.
module pb_debounce_multi #(
   parameter int NUM_PB        = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int DB_CYCLES     = 4,
   parameter int LONG_CYCLES   = 10,
   parameter int REPEAT_CYCLES = 5,
   parameter int ACTIVE_LOW    = 1
) (
   input logic                clk,
   input logic                rst_n,
   pb_debounce_multi_if.slave bus
);

   localparam int   DB_W     = $clog2(DB_CYCLES + 1);
   localparam int   HOLD_W   = $clog2(LONG_CYCLES + 1);
   // raw input value of a released button
   localparam logic INACTIVE = (ACTIVE_LOW != 0);
`ifdef PB_AUTOREPEAT_EN
   localparam int   REP_W    = $clog2(REPEAT_CYCLES + 1);
`endif

   // Reject parameter values the counters cannot represent sensibly.
   if (NUM_PB < 1 || SYNC_STAGES < 2 || DB_CYCLES < 1 || LONG_CYCLES < 2 || REPEAT_CYCLES < 1)
   begin : g_param_check
      $error("pb_debounce_multi: illegal parameter value");
   end

   for (genvar g = 0; g < NUM_PB; g++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic [DB_W-1:0]        db_cnt;
      logic [HOLD_W-1:0]      hold_cnt;
      logic                   level_q;
      logic                   pressed_q;
      logic                   released_q;
      logic                   long_q;
      logic                   s;
      logic                   flip;
      logic                   hold_fire;
      logic                   rep_fire;

      // s = 1 means "pressed" regardless of the electrical polarity
      assign s         = sync_q[SYNC_STAGES-1] ^ INACTIVE;
      // the new value has persisted long enough: level toggles on this edge
      assign flip      = (s != level_q) && (db_cnt == DB_W'(DB_CYCLES - 1));
      // hold counter is about to reach LONG_CYCLES; never on a release edge
      assign hold_fire = level_q && !flip && (hold_cnt == HOLD_W'(LONG_CYCLES - 1));

      // Synchroniser chain; resets to the idle (released) electrical level.
      always_ff @(posedge clk) begin
         if (!rst_n) sync_q <= {SYNC_STAGES{INACTIVE}};
         else        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.PB[g]};
      end

      // Debounce counter: counts consecutive cycles the input differs from level.
      always_ff @(posedge clk) begin
         if (!rst_n || s == level_q || flip) db_cnt <= '0;
         else                                db_cnt <= db_cnt + DB_W'(1);
      end

      // Hold counter: runs from the press event while pressed, saturating at LONG_CYCLES.
      always_ff @(posedge clk) begin
         if (!rst_n || !level_q || flip)          hold_cnt <= '0;
         else if (hold_cnt != HOLD_W'(LONG_CYCLES)) hold_cnt <= hold_cnt + HOLD_W'(1);
      end

`ifdef PB_AUTOREPEAT_EN
      logic [REP_W-1:0] rep_cnt;
      logic             hold_sat;

      assign hold_sat = (hold_cnt == HOLD_W'(LONG_CYCLES));
      assign rep_fire = level_q && !flip && hold_sat && (rep_cnt == REP_W'(REPEAT_CYCLES - 1));

      // Repeat counter: restarts at the first long_press and after every repeat.
      always_ff @(posedge clk) begin
         if (!rst_n || !level_q || flip || !hold_sat || rep_fire) rep_cnt <= '0;
         else                                                     rep_cnt <= rep_cnt + REP_W'(1);
      end
`else
      assign rep_fire = 1'b0;
`endif

      // Registered level and event pulses; press, release and long are exclusive by construction.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            level_q    <= 1'b0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
            long_q     <= 1'b0;
         end else begin
            level_q    <= level_q ^ flip;
            pressed_q  <= flip && !level_q;
            released_q <= flip && level_q;
            long_q     <= hold_fire || rep_fire;
         end
      end

      assign bus.level[g]      = level_q;
      assign bus.pressed[g]    = pressed_q;
      assign bus.released[g]   = released_q;
      assign bus.long_press[g] = long_q;
   end

endmodule

// File: tb/tb_pb_debounce_multi.sv
// tb_pb_debounce_multi: scoreboard bench for pb_debounce_multi at default parameters.
// Expected events are queued when PB changes and matched against pulses every cycle.
// Honours PB_AUTOREPEAT_EN for the extra long_press repeats.
`timescale 1ns/1ps
module tb_pb_debounce_multi;
   localparam int NUM_PB = 4;
   localparam int K_PRESS = 0;
   localparam int K_REL   = 1;
   localparam int K_LONG  = 2;

   typedef struct {
      int cyc;
      int ch;
      int kind;
   } ev_t;

   logic              clk = 1'b0;
   logic              rst_n;
   int                edge_n = 0;
   int                checks = 0;
   int                failures = 0;
   bit                mon_en = 1'b0;
   ev_t               sb[$];
   ev_t               keep[$];
   logic [NUM_PB-1:0] exp_level = '0;
   logic [NUM_PB-1:0] e_pr;
   logic [NUM_PB-1:0] e_rl;
   logic [NUM_PB-1:0] e_lp;

   pb_debounce_multi_if #(.NUM_PB(NUM_PB)) bus ();

   pb_debounce_multi #(.NUM_PB(NUM_PB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // clock edge counter used to timestamp expected events
   always @(posedge clk) edge_n <= edge_n + 1;

   // queue an event rel edges after now (rel=1 is the next rising edge)
   function automatic void expect_ev(int rel, int ch, int kind);
      ev_t e;
      e.cyc  = edge_n + rel;
      e.ch   = ch;
      e.kind = kind;
      sb.push_back(e);
   endfunction

   task automatic cycles(int n);
      repeat (n) @(negedge clk);
   endtask

   // scoreboard monitor: pop events due this cycle and compare every output
   always @(negedge clk) begin
      if (mon_en) begin
         e_pr = '0;
         e_rl = '0;
         e_lp = '0;
         keep.delete();
         foreach (sb[i]) begin
            if (sb[i].cyc == edge_n) begin
               case (sb[i].kind)
                  K_PRESS: e_pr[sb[i].ch] = 1'b1;
                  K_REL:   e_rl[sb[i].ch] = 1'b1;
                  default: e_lp[sb[i].ch] = 1'b1;
               endcase
            end else if (sb[i].cyc < edge_n) begin
               checks++;
               failures++;
               $display("FAIL missed_event ch=%0d kind=%0d due=%0d now=%0d", sb[i].ch, sb[i].kind, sb[i].cyc, edge_n);
            end else begin
               keep.push_back(sb[i]);
            end
         end
         sb = keep;
         exp_level = (exp_level | e_pr) & ~e_rl;
         checks += 4;
         if (bus.pressed !== e_pr) begin
            failures++;
            $display("FAIL pressed cyc=%0d got=%b expected=%b", edge_n, bus.pressed, e_pr);
         end
         if (bus.released !== e_rl) begin
            failures++;
            $display("FAIL released cyc=%0d got=%b expected=%b", edge_n, bus.released, e_rl);
         end
         if (bus.long_press !== e_lp) begin
            failures++;
            $display("FAIL long_press cyc=%0d got=%b expected=%b", edge_n, bus.long_press, e_lp);
         end
         if (bus.level !== exp_level) begin
            failures++;
            $display("FAIL level cyc=%0d got=%b expected=%b", edge_n, bus.level, exp_level);
         end
      end
   end

   task automatic test_reset();
      rst_n  = 1'b0;
      bus.PB = '1;
      @(posedge clk);
      #1 mon_en = 1'b1;
      cycles(5);
      checks++;
      if ({bus.level, bus.pressed, bus.released, bus.long_press} !== 16'h0) begin
         failures++;
         $display("FAIL reset_state got=%h expected=0000", {bus.level, bus.pressed, bus.released, bus.long_press});
      end
      rst_n = 1'b1;
      cycles(50);
      checks++;
      if (bus.level !== 4'b0000) begin
         failures++;
         $display("FAIL reset_idle_level got=%b expected=0000", bus.level);
      end
   endtask

   task automatic test_press_release();
      bus.PB[0] = 1'b0;
      expect_ev(6, 0, K_PRESS);
      cycles(6);
      checks++;
      if (bus.level !== 4'b0001) begin
         failures++;
         $display("FAIL press_level got=%b expected=0001", bus.level);
      end
      cycles(2);
      bus.PB[0] = 1'b1;
      expect_ev(6, 0, K_REL);
      cycles(10);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL press_release_pending got=%0d expected=0", sb.size());
      end
   endtask

   task automatic test_bounce();
      repeat (4) begin
         bus.PB[1] = 1'b0;
         cycles(3);
         bus.PB[1] = 1'b1;
         cycles(2);
      end
      cycles(10);
      checks++;
      if (bus.level[1] !== 1'b0) begin
         failures++;
         $display("FAIL bounce_level got=%b expected=0", bus.level[1]);
      end
   endtask

   task automatic test_long_press();
      bus.PB[2] = 1'b0;
      expect_ev(6, 2, K_PRESS);
      expect_ev(16, 2, K_LONG);
`ifdef PB_AUTOREPEAT_EN
      expect_ev(21, 2, K_LONG);
      expect_ev(26, 2, K_LONG);
      expect_ev(31, 2, K_LONG);
`endif
      expect_ev(36, 2, K_REL);
      cycles(30);
      checks++;
      if (bus.level !== 4'b0100) begin
         failures++;
         $display("FAIL long_held_level got=%b expected=0100", bus.level);
      end
      bus.PB[2] = 1'b1;
      cycles(12);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL long_pending got=%0d expected=0", sb.size());
      end
   endtask

   task automatic test_simultaneous();
      bus.PB[0] = 1'b0;
      bus.PB[3] = 1'b0;
      expect_ev(6, 0, K_PRESS);
      expect_ev(6, 3, K_PRESS);
      cycles(6);
      checks++;
      if (bus.pressed !== 4'b1001 || bus.level !== 4'b1001) begin
         failures++;
         $display("FAIL simultaneous got=%b/%b expected=1001/1001", bus.pressed, bus.level);
      end
      cycles(2);
      bus.PB[0] = 1'b1;
      bus.PB[3] = 1'b1;
      expect_ev(6, 0, K_REL);
      expect_ev(6, 3, K_REL);
      cycles(10);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL simultaneous_pending got=%0d expected=0", sb.size());
      end
   endtask

   task automatic test_reset_mid_debounce();
      bus.PB[0] = 1'b0;
      cycles(2);
      rst_n = 1'b0;
      cycles(2);
      checks++;
      if ({bus.level, bus.pressed} !== 8'h00) begin
         failures++;
         $display("FAIL mid_reset_state got=%h expected=00", {bus.level, bus.pressed});
      end
      rst_n = 1'b1;
      expect_ev(6, 0, K_PRESS);
      cycles(8);
      checks++;
      if (bus.level !== 4'b0001) begin
         failures++;
         $display("FAIL mid_reset_redetect got=%b expected=0001", bus.level);
      end
      bus.PB[0] = 1'b1;
      expect_ev(6, 0, K_REL);
      cycles(10);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL mid_reset_pending got=%0d expected=0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_press_release();
      test_bounce();
      test_long_press();
      test_simultaneous();
      test_reset_mid_debounce();
      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pb_debounce_multi.md
Name: pb_debounce_multi

Overview:
Multi-channel push-button conditioner for the flight-controller user inputs.
- Per channel: synchronises the raw input, debounces it with a programmable stable-time counter, and emits one-cycle press, release and long-press events plus a debounced level.
- Replaces single-channel, release-only edge detection with a parametrised channel count, polarity and timing.

Parameters:
NUM_PB, 4, number of independent button channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DB_CYCLES, 4, consecutive cycles a new synchronised value must persist before acceptance (>=1)
LONG_CYCLES, 10, cycles after the press event at which long_press fires (>=2)
REPEAT_CYCLES, 5, auto-repeat period; used only with PB_AUTOREPEAT_EN (>=1)
ACTIVE_LOW, 1, 1: PB=0 means pressed; 0: PB=1 means pressed

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
PB  input  NUM_PB  raw asynchronous button inputs
level  output  NUM_PB  debounced state, 1 = pressed (polarity-normalised)
pressed  output  NUM_PB  one-cycle pulse on accepted press
released  output  NUM_PB  one-cycle pulse on accepted release
long_press  output  NUM_PB  one-cycle pulse on long hold (plus repeats with macro)

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk. On reset:
  - Synchroniser flops load the inactive level (1 if ACTIVE_LOW, else 0).
  - All counters clear; level, pressed, released and long_press are all 0.
  - No event pulses occur during reset or on the first cycle after it.
- Per-channel datapath; channels are fully independent, with no shared state or arbitration.
- Synchroniser: SYNC_STAGES-flop chain. s = last stage XOR ACTIVE_LOW, so s=1 means pressed.
- Debounce counter db_cnt, width $clog2(DB_CYCLES+1):
  - s == level: db_cnt <= 0.
  - s != level and db_cnt < DB_CYCLES-1: db_cnt increments.
  - s != level and db_cnt == DB_CYCLES-1: level toggles, db_cnt <= 0, and pressed or released pulses on the same edge (registered).
- Any bounce shorter than DB_CYCLES clears db_cnt; no event, level unchanged.
- Latency: pulse and level change appear SYNC_STAGES+DB_CYCLES clocks after PB first samples the new value. Defaults: 6 clocks.
- Hold counter hold_cnt, width $clog2(LONG_CYCLES+1):
  - Cleared on the pressed pulse.
  - Increments each cycle while level=1; saturates at LONG_CYCLES.
  - long_press pulses on the edge where hold_cnt reaches LONG_CYCLES, i.e. LONG_CYCLES clocks after pressed. At most once per press without the macro.
  - Cleared when level=0.
- Simultaneous events:
  - A cycle where level flips to 0 never produces long_press.
  - A release before LONG_CYCLES produces released only.
  - pressed, released and long_press are mutually exclusive per channel per cycle.
- Reset mid-debounce or mid-hold: all state discarded. A still-held button is re-detected with full latency after reset deasserts.
- Outputs are driven directly from flops; no combinational path from PB.

Optional Feature:
Macro PB_AUTOREPEAT_EN.
- Defined: after the first long_press, a repeat counter restarts. long_press pulses again every REPEAT_CYCLES clocks while level=1. Counter clears on release; the cycle where level flips to 0 never pulses.
- Undefined: no repeat logic is generated; REPEAT_CYCLES is ignored; long_press fires once per press.

Test Plan:
All scenarios use default parameters. Cycle counts are relative to the first clock edge sampling the changed PB.
- Reset: rst_n=0 for 5 cycles with PB=4'hF, then released -> level=0 and no pulses for 50 cycles.
- Clean press/release ch0:
  - PB[0]=0 held -> pressed[0] single pulse and level[0]=1 at cycle 6.
  - PB[0]=1 -> released[0] pulse at cycle 6 after that change.
  - Other channels stay silent.
- Bounce ch1: PB[1]=0 for 3 cycles, then 1, repeated 4 times -> no pulses, level[1]=0 throughout.
- Long press ch2: PB[2]=0 held 30 cycles -> pressed[2]@6, long_press[2]@16, released[2]@36.
  - Macro on: extra long_press[2]@21, 26 and 31; none @36.
- Simultaneous ch0 and ch3 pressed same cycle -> both pressed pulses @6 in the same cycle, level=4'b1001.
- Reset mid-debounce: PB[0]=0, rst_n=0 at cycle 3 for 2 cycles, PB[0] held -> no pulse before reset; pressed[0] 6 cycles after rst_n returns high.
